// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 512;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage for sync_fifo_param. Registered read by default;
// asynchronous read when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic unused_ctrl;
    assign unused_ctrl = rd_en ^ rst;
    assign rd_data     = mem_q[rd_addr];
`else
    logic [DATA_W-1:0] rd_data_q;

    // Output register resets to zero and holds between accepted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, thresholds, flush and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read behaviour.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          full_q, empty_q, almost_full_q, almost_empty_q;
    logic          overflow_q, underflow_q;
    logic          wr_acc, rd_acc;

    // Flush drops both requests outright, so neither side may be accepted.
    assign wr_acc = wr_en && !full_q  && !flush;
    assign rd_acc = rd_en && !empty_q && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= (count_d == PW'(DEPTH));
            empty_q        <= (count_d == '0);
            almost_full_q  <= (count_d >= PW'(AF_THRESH));
            almost_empty_q <= (count_d <= PW'(AE_THRESH));
            overflow_q     <= wr_en && full_q && !flush;
            underflow_q    <= rd_en && empty_q && !flush;
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc && !rst),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_acc && !rst),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (rd_data)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_valid = !empty_q;
`else
    logic rd_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
        end
    end

    assign rd_valid = rd_valid_q;
`endif

    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param (DEPTH=8, AF=6, AE=1).
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty;
    logic [3:0] count;
    logic       overflow, underflow;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic step(input logic w, input logic [7:0] wd, input logic r);
        wr_en = w; wr_data = wd; rd_en = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    // Monitor: every presented word must match the oldest expected word.
`ifndef SYNC_FIFO_FWFT_EN
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst && rd_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rd_data unexpected: got %0h expected none", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", rd_data, e);
                end
            end
        end
    end
`endif

    task automatic std_tests();
        // Reset state
        check("rst count", count, 0);
        check("rst empty", empty, 1);
        check("rst almost_empty", almost_empty, 1);
        check("rst full", full, 0);
        check("rst rd_valid", rd_valid, 0);
        check("rst rd_data", rd_data, 8'h00);

        // Read while empty
        step(0, 8'h00, 1);
        check("uf pulse", underflow, 1);
        check("uf count", count, 0);
        check("uf rd_valid", rd_valid, 0);
        step(0, 8'h00, 0);
        check("uf clears", underflow, 0);

        // Fill 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            step(1, 8'(i), 0);
            check("fill count", count, i);
            check("fill almost_empty", almost_empty, (i <= 1));
            check("fill almost_full", almost_full, (i >= 6));
            check("fill full", full, (i == 8));
        end

        // Overflow
        step(1, 8'h09, 0);
        check("of pulse", overflow, 1);
        check("of count", count, 8);
        step(0, 8'h00, 0);
        check("of clears", overflow, 0);

        // Drain
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(8'(i));
            step(0, 8'h00, 1);
            check("drain count", count, 8 - i);
        end
        check("drain empty", empty, 1);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        check("rd_valid pulse ends", rd_valid, 0);

        // Wrap-around: 4 rounds of 5 in, 5 out
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 5; k++) step(1, 8'(8'h10 * (r + 1) + k), 0);
            check("wrap count", count, 5);
            for (int k = 0; k < 5; k++) begin
                exp_q.push_back(8'(8'h10 * (r + 1) + k));
                step(0, 8'h00, 1);
            end
            check("wrap empty", empty, 1);
        end

        // Full with simultaneous read and write
        for (int k = 0; k < 8; k++) step(1, 8'(8'h30 + k), 0);
        check("full set", full, 1);
        exp_q.push_back(8'h30);
        step(1, 8'hEE, 1);
        check("full rw overflow", overflow, 1);
        check("full rw count", count, 7);
        for (int k = 1; k < 8; k++) begin
            exp_q.push_back(8'(8'h30 + k));
            step(0, 8'h00, 1);
        end
        check("full rw drained", count, 0);
        step(0, 8'h00, 0);

        // Empty with simultaneous read and write
        step(1, 8'h55, 1);
        check("empty rw underflow", underflow, 1);
        check("empty rw count", count, 1);
        check("empty rw rd_valid", rd_valid, 0);
        exp_q.push_back(8'h55);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0);

        // Flush with data present and a concurrent write
        for (int k = 0; k < 5; k++) step(1, 8'(8'h60 + k), 0);
        check("pre-flush count", count, 5);
        flush = 1'b1;
        step(1, 8'h99, 0);
        flush = 1'b0;
        check("flush count", count, 0);
        check("flush empty", empty, 1);
        check("flush overflow", overflow, 0);
        check("flush almost_empty", almost_empty, 1);
        check("flush almost_full", almost_full, 0);
        check("flush rd_data held", rd_data, 8'h55);
        step(1, 8'h77, 0);
        exp_q.push_back(8'h77);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0);

        // Reset mid-operation
        for (int k = 0; k < 3; k++) step(1, 8'(8'h80 + k), 0);
        rst = 1'b1;
        step(1, 8'h88, 1);
        rst = 1'b0;
        check("midrst count", count, 0);
        check("midrst empty", empty, 1);
        check("midrst rd_data", rd_data, 8'h00);
        check("midrst rd_valid", rd_valid, 0);
    endtask

    task automatic fwft_tests();
        check("rst count", count, 0);
        check("rst empty", empty, 1);
        check("rst rd_valid", rd_valid, 0);
        step(1, 8'hA5, 0);
        check("fwft rd_valid", rd_valid, 1);
        check("fwft rd_data", rd_data, 8'hA5);
        step(0, 8'h00, 1);
        check("fwft pop rd_valid", rd_valid, 0);
        check("fwft pop count", count, 0);
        step(0, 8'h00, 1);
        check("fwft underflow", underflow, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
        fwft_tests();
`else
        std_tests();
`endif
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
